alut_addr_learn6: RTL

Address lookup/learning stage of the ALUT, sitting directly upstream of the age checker. For each frame request it writes the source MAC, port and current time into the 256-entry ALUT memory, then looks up the destination MAC. On a hit it hands the stored timestamp to the age checker through `check_age6`/`last_accessed6` and returns a one-hot destination port or a flood indication. It owns the ALUT memory port whenever `add_check_active6` is high.

---
 rtl/alut_defs6_pkg.sv | 36 +++
 rtl/alut_addr_learn6.sv | 133 +++++++++++++
 2 files changed

// File: rtl/alut_defs6_pkg.sv
// Shared ALUT definitions: entry field layout, special addresses and the
// address-checker FSM encoding, plus the MAC hash fold.
package alut_defs6;

    localparam int ENTRY_W   = 83;
    localparam int VALID_BIT = 82;
    localparam int TIME_MSB  = 81;
    localparam int TIME_LSB  = 50;
    localparam int PORT_MSB  = 49;
    localparam int PORT_LSB  = 48;
    localparam int MAC_MSB   = 47;
    localparam int MAC_LSB   = 0;

    localparam logic [47:0] BCAST_MAC = 48'hffff_ffff_ffff;
    localparam logic [4:0]  FLOOD     = 5'b10000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SRC,
        ST_RD_DST,
        ST_CHK_DST,
        ST_AGE_REQ,
        ST_AGE_WAIT,
        ST_RESP
    } addr_state_e;

    // XOR fold of the six MAC bytes into an 8-bit table index.
    function automatic logic [7:0] mac_hash(input logic [47:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ a[39:32] ^ a[47:40];
    endfunction

    function automatic logic [4:0] port_onehot(input logic [1:0] port);
        return 5'(5'b00001 << port);
    endfunction

endpackage

// File: rtl/alut_addr_learn6.sv
// ALUT address learn/lookup stage: learns the source MAC, looks up the
// destination MAC and consults the age checker before returning a port.
module alut_addr_learn6
    import alut_defs6::*;
(
    input  logic                 pclk6,
    input  logic                 n_p_reset6,
    input  logic                 addr_req6,
    input  logic [47:0]          s_addr6,
    input  logic [47:0]          d_addr6,
    input  logic [1:0]           s_port6,
    input  logic [31:0]          curr_time6,
    input  logic                 age_check_active6,
    input  logic                 age_confirmed6,
    input  logic                 age_ok6,
    input  logic [ENTRY_W-1:0]   mem_read_data_add6,
    output logic [7:0]           mem_addr_add6,
    output logic                 mem_write_add6,
    output logic [ENTRY_W-1:0]   mem_write_data_add6,
    output logic                 check_age6,
    output logic [31:0]          last_accessed6,
    output logic                 add_check_active6,
    output logic                 addr_ack6,
    output logic [4:0]           d_port6
);

    addr_state_e        state_q, state_d;
    logic [47:0]        d_addr_q, d_addr_d;
    logic [7:0]         mem_addr_q, mem_addr_d;
    logic               mem_write_q, mem_write_d;
    logic [ENTRY_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [31:0]        last_acc_q, last_acc_d;
    logic [1:0]         hit_port_q, hit_port_d;
    logic [4:0]         d_port_q, d_port_d;

    logic accept;
    logic dst_hit;

    assign accept  = (state_q == ST_IDLE) & addr_req6 & ~age_check_active6;
    assign dst_hit = mem_read_data_add6[VALID_BIT] &
                     (mem_read_data_add6[MAC_MSB:MAC_LSB] == d_addr_q);

    // NOTE: every always_comb output gets its default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d     = state_q;
        d_addr_d    = d_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_write_d = 1'b0;
        mem_wdata_d = mem_wdata_q;
        last_acc_d  = last_acc_q;
        hit_port_d  = hit_port_q;
        d_port_d    = d_port_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_WR_SRC;
                    d_addr_d    = d_addr6;
                    mem_addr_d  = mac_hash(s_addr6);
                    mem_write_d = 1'b1;
                    mem_wdata_d = {1'b1, curr_time6, s_port6, s_addr6};
                end
            end
            // Learning is unconditional: a colliding entry is simply replaced.
            ST_WR_SRC: begin
                if (d_addr_q == BCAST_MAC) begin
                    d_port_d = FLOOD;
                    state_d  = ST_RESP;
                end else begin
                    mem_addr_d = mac_hash(d_addr_q);
                    state_d    = ST_RD_DST;
                end
            end
            ST_RD_DST: state_d = ST_CHK_DST;
            ST_CHK_DST: begin
                if (dst_hit) begin
                    last_acc_d = mem_read_data_add6[TIME_MSB:TIME_LSB];
                    hit_port_d = mem_read_data_add6[PORT_MSB:PORT_LSB];
                    state_d    = ST_AGE_REQ;
                end else begin
                    d_port_d = FLOOD;
                    state_d  = ST_RESP;
                end
            end
            ST_AGE_REQ: state_d = ST_AGE_WAIT;
            // Stale entries are flooded here; clearing them is the age checker's job.
            ST_AGE_WAIT: begin
                if (age_confirmed6) begin
                    d_port_d = age_ok6 ? port_onehot(hit_port_q) : FLOOD;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge pclk6 or negedge n_p_reset6) begin
        if (!n_p_reset6) begin
            state_q     <= ST_IDLE;
            d_addr_q    <= '0;
            mem_addr_q  <= '0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
            last_acc_q  <= '0;
            hit_port_q  <= '0;
            d_port_q    <= '0;
        end else begin
            state_q     <= state_d;
            d_addr_q    <= d_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_write_q <= mem_write_d;
            mem_wdata_q <= mem_wdata_d;
            last_acc_q  <= last_acc_d;
            hit_port_q  <= hit_port_d;
            d_port_q    <= d_port_d;
        end
    end

    // Ownership is claimed combinationally so arbitration sees it in the accept cycle.
    assign add_check_active6   = (state_q != ST_IDLE) | accept;
    assign check_age6          = (state_q == ST_AGE_REQ);
    assign addr_ack6           = (state_q == ST_RESP);
    assign mem_addr_add6       = mem_addr_q;
    assign mem_write_add6      = mem_write_q;
    assign mem_write_data_add6 = mem_wdata_q;
    assign last_accessed6      = last_acc_q;
    assign d_port6             = d_port_q;

endmodule
